// File: rtl/ad9361_stim_pkg.sv
// Shared encodings and PN9 definition for the AD9361 receive-side stimulus generator.
package ad9361_stim_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'd0,
    MODE_CONST  = 2'd1,
    MODE_PN9    = 2'd2,
    MODE_STREAM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [8:0] PN9_SEED   = 9'h1FF;
  localparam int         PN9_TAP_HI = 8;
  localparam int         PN9_TAP_LO = 4;

  // x^9 + x^5 + 1, shifting towards the MSB
  function automatic logic [8:0] pn9_next(input logic [8:0] s);
    pn9_next = {s[7:0], s[PN9_TAP_HI] ^ s[PN9_TAP_LO]};
  endfunction

endpackage

// File: rtl/ad9361_stim_lfsr.sv
// PN9 generator; reseed together with advance yields the state one step past the seed.
module ad9361_stim_lfsr
  import ad9361_stim_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_advance,
  input  logic       i_reseed,
  output logic [8:0] o_state
);

  logic [8:0] r_state;

  // LFSR state register
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= PN9_SEED;
    end else if (i_reseed) begin
      r_state <= i_advance ? pn9_next(PN9_SEED) : PN9_SEED;
    end else if (i_advance) begin
      r_state <= pn9_next(r_state);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ad9361_rx_stim.sv
// AD9361 receive data-port stimulus: emits framed half-sample beats from
// ramp, constant, PN9 or an external stream, with burst and underflow status.
module ad9361_rx_stim
  import ad9361_stim_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int DW     = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DW-1:0]            const_i,
  input  logic [DW-1:0]            const_q,
  input  logic [15:0]              burst_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [2*DW*NUM_CH-1:0]   s_data,
  input  logic                     clear,
  output logic                     rx_frame,
  output logic [DW/2-1:0]          rx_data,
  output logic                     busy,
  output logic                     done,
  output logic                     underflow
);

  localparam int         BW        = DW / 2;
  localparam int         SW        = 2 * DW * NUM_CH;
  localparam logic [2:0] LAST_BEAT = 3'(4 * NUM_CH - 1);

  state_e          r_state, w_state_nxt;
  mode_e           r_mode, w_mode_nxt, w_mode_in;
  logic [2:0]      r_beat, w_beat_nxt, w_beat_inc;
  logic [15:0]     r_fcnt, w_fcnt_nxt;
  logic [DW-1:0]   r_ramp, w_ramp_nxt;
  logic [SW-1:0]   r_smp, w_smp_nxt, w_src;
  logic            r_rx_frame, w_frame_nxt;
  logic [BW-1:0]   r_rx_data, w_data_nxt;
  logic            r_done, w_done_nxt;
  logic            r_underflow;
  logic            w_frame_end, w_burst_end, w_load, w_starve;
  logic            w_pn_adv, w_pn_reseed;
  logic [8:0]      w_pn;
  logic            w_pn_unused;

  // Beat b of a frame: channel from b[2] (two-channel only), quarter from b[1:0]
  function automatic logic [BW-1:0] beat_of(input logic [SW-1:0] smp, input logic [2:0] b);
    logic [2*DW-1:0] v_ch;
    logic [DW-1:0]   v_i;
    logic [DW-1:0]   v_q;
    v_ch = (NUM_CH == 2 && b[2]) ? smp[SW-1 -: 2*DW] : smp[2*DW-1:0];
    v_i  = v_ch[DW-1:0];
    v_q  = v_ch[2*DW-1:DW];
    case (b[1:0])
      2'd0:    beat_of = v_i[DW-1:BW];
      2'd1:    beat_of = v_q[DW-1:BW];
      2'd2:    beat_of = v_i[BW-1:0];
      default: beat_of = v_q[BW-1:0];
    endcase
  endfunction

  ad9361_stim_lfsr u_lfsr (
    .i_clk     (clk),
    .i_resetn  (resetn),
    .i_advance (w_pn_adv),
    .i_reseed  (w_pn_reseed),
    .o_state   (w_pn)
  );

  assign w_pn_unused = ^w_pn;
  assign w_mode_in   = mode_e'(mode);
  assign w_beat_inc  = r_beat + 3'd1;
  assign w_frame_end = (r_state == ST_RUN) && (r_beat == LAST_BEAT);
  assign w_burst_end = w_frame_end && (burst_len != 16'd0) && ((r_fcnt + 16'd1) == burst_len);
  assign w_load      = resetn && enable &&
                       ((r_state == ST_IDLE) || (w_frame_end && !w_burst_end));
  assign w_starve    = w_load && (w_mode_in == MODE_STREAM) && !s_valid;

  // Samples for the frame being loaded, laid out {Q,I} per channel
  always_comb begin
    w_src = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      case (w_mode_in)
        MODE_RAMP: begin
          w_src[c*2*DW +: DW]      = r_ramp + DW'(c);
          w_src[c*2*DW + DW +: DW] = ~(r_ramp + DW'(c));
        end
        MODE_CONST: begin
          w_src[c*2*DW +: DW]      = const_i;
          w_src[c*2*DW + DW +: DW] = const_q;
        end
        MODE_STREAM: w_src[c*2*DW +: 2*DW] = s_valid ? s_data[c*2*DW +: 2*DW] : '0;
        default:     w_src[c*2*DW +: 2*DW] = '0;
      endcase
    end
  end

  // Next state, beat sequencing and next output beat
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_beat_nxt  = r_beat;
    w_fcnt_nxt  = r_fcnt;
    w_ramp_nxt  = r_ramp;
    w_smp_nxt   = r_smp;
    w_frame_nxt = 1'b0;
    w_data_nxt  = '0;
    w_done_nxt  = 1'b0;
    w_pn_adv    = 1'b0;
    w_pn_reseed = 1'b0;
    if (w_load) begin
      w_state_nxt = ST_RUN;
      w_mode_nxt  = w_mode_in;
      w_beat_nxt  = 3'd0;
      w_fcnt_nxt  = (r_state == ST_IDLE) ? 16'd0 : r_fcnt + 16'd1;
      w_ramp_nxt  = (w_mode_in == MODE_RAMP) ? r_ramp + DW'(1) : r_ramp;
      w_smp_nxt   = w_src;
      w_frame_nxt = 1'b1;
      w_pn_reseed = (r_state == ST_IDLE);
      w_pn_adv    = (w_mode_in == MODE_PN9);
      if (w_mode_in == MODE_PN9) begin
        w_data_nxt = (r_state == ST_IDLE) ? PN9_SEED[BW-1:0] : w_pn[BW-1:0];
      end else begin
        w_data_nxt = beat_of(w_src, 3'd0);
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!w_frame_end) begin
            w_beat_nxt  = w_beat_inc;
            w_frame_nxt = (NUM_CH == 1) ? ~w_beat_inc[1] : ~w_beat_inc[2];
            w_pn_adv    = (r_mode == MODE_PN9);
            w_data_nxt  = (r_mode == MODE_PN9) ? w_pn[BW-1:0] : beat_of(r_smp, w_beat_inc);
          end else if (w_burst_end) begin
            w_state_nxt = ST_HOLD;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HOLD: w_state_nxt = enable ? ST_HOLD : ST_IDLE;
        ST_IDLE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_RAMP;
      r_beat      <= 3'd0;
      r_fcnt      <= 16'd0;
      r_ramp      <= '0;
      r_smp       <= '0;
      r_rx_frame  <= 1'b0;
      r_rx_data   <= '0;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_beat      <= w_beat_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_ramp      <= w_ramp_nxt;
      r_smp       <= w_smp_nxt;
      r_rx_frame  <= w_frame_nxt;
      r_rx_data   <= w_data_nxt;
      r_done      <= w_done_nxt;
      r_underflow <= w_starve ? 1'b1 : (clear ? 1'b0 : r_underflow);
    end
  end

  assign s_ready   = w_load && (w_mode_in == MODE_STREAM);
  assign rx_frame  = r_rx_frame;
  assign rx_data   = r_rx_data;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign underflow = r_underflow;

endmodule

// File: doc/ad9361_rx_stim.md
AD9361_RX_STIM -- requirements
Module: ad9361_rx_stim

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, meaning receive channels per frame (legal values 1 or 2).
REQ-002 SHALL have parameter DW, default 12, meaning sample width per I or Q (even, 8..18); beat width BW = DW/2.
REQ-003 SHALL have port clk, in, 1, meaning the single clock; one beat per cycle.
REQ-004 SHALL have port resetn, in, 1, meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable, in, 1, meaning run request.
REQ-006 SHALL have port mode, in, 2, meaning 0 ramp, 1 constant, 2 PN9, 3 external stream.
REQ-007 SHALL have port const_i / const_q, in, DW each, meaning constant-mode sample.
REQ-008 SHALL have port burst_len, in, 16, meaning frames per run; 0 = continuous.
REQ-009 SHALL have port s_valid, in, 1 / s_ready, out, 1 / s_data, in, 2*DW*NUM_CH, meaning the external sample stream; channel c at {Q,I} slice c.
REQ-010 SHALL have port clear, in, 1, meaning synchronous clear of underflow.
REQ-011 SHALL have port rx_frame, out, 1 / rx_data, out, BW, meaning the generated frame and data beats.
REQ-012 SHALL have port busy, out, 1 / done, out, 1 / underflow, out, 1, meaning status.

Function
REQ-013 SHALL define a frame as F = 4*NUM_CH beats; per channel c the beat order SHALL be I[DW-1:BW], Q[DW-1:BW], I[BW-1:0], Q[BW-1:0].
REQ-014 SHALL drive rx_frame high for beats 0-1 and low for beats 2-3 when NUM_CH=1; SHALL drive it high for channel 0 beats and low for channel 1 beats when NUM_CH=2.
REQ-015 SHALL implement states IDLE, RUN and HOLD; IDLE->RUN when enable=1; RUN->IDLE at a frame end with enable=0; RUN->HOLD at the frame end completing burst_len frames (burst_len!=0); HOLD->IDLE when enable=0.
REQ-016 SHALL define the load cycle as an IDLE cycle with enable=1, or a RUN cycle on beat F-1 when the run continues; mode and sample source SHALL be sampled only on load cycles.
REQ-017 SHALL register rx_data and rx_frame so that beat 0 of a loaded frame appears the cycle after its load cycle; frames SHALL be back-to-back with no gap.
REQ-018 SHALL never truncate a frame: enable deassertion mid-frame SHALL finish the current frame first.
REQ-019 Ramp mode: counter n (DW bits, reset 0) SHALL advance by 1 per frame and wrap from 2^DW-1 to 0; channel c SHALL send I=n+c mod 2^DW and Q=~I.
REQ-020 Constant mode: every channel SHALL send const_i/const_q as captured at load.
REQ-021 PN9 mode: an x^9+x^5+1 LFSR (seed 0x1FF on reset and on IDLE->RUN) SHALL advance once per beat, with rx_data = state[BW-1:0].
REQ-022 Stream mode: s_ready SHALL be high exactly on load cycles; on s_valid=0 at a load cycle the frame SHALL send all-zero samples and set underflow sticky.
REQ-023 clear SHALL clear underflow; a simultaneous new underflow SHALL win.
REQ-024 done SHALL pulse for one cycle on the cycle after the last beat of a burst; busy SHALL equal (state==RUN).
REQ-025 In IDLE and HOLD, rx_frame and rx_data SHALL be 0 and s_ready SHALL be 0.

Reset
REQ-026 On resetn=0 the state SHALL be IDLE, the counters 0, the LFSR 0x1FF, and rx_frame, rx_data, s_ready, busy, done and underflow all 0, including when reset arrives mid-frame.
REQ-027 After resetn deasserts, the first load cycle SHALL occur no earlier than the first clk edge with enable=1.

Structure
REQ-028 Package ad9361_stim_pkg SHALL hold the mode and state encodings, the PN9 seed and the taps.
REQ-029 The PN9 generator SHALL be sub-module ad9361_stim_lfsr (advance, reseed, 9-bit state output).

Verification
REQ-030 Ramp test: NUM_CH=1, DW=12, enable held -> beats 0x00,0x3F,0x00,0x3F then 0x00,0x3F,0x01,0x3E, with rx_frame 1,1,0,0 repeating.
REQ-031 Burst test: burst_len=3, mode 1, const 0xABC/0x123 -> exactly 12 beats 0x2A,0x04,0x3C,0x23 repeated, one done pulse, busy low afterwards, 0 until enable drops and rises again.
REQ-032 Stream test: NUM_CH=2, s_valid low at the second load -> second frame is 8 zero beats, underflow=1; clear with no new underflow -> 0.
REQ-033 PN9 test: the first 20 beats match the reference LFSR model from seed 0x1FF, and the generator reseeds on restart.
REQ-034 Enable dropped on beat 1 -> beats 2..F-1 still emitted, then IDLE with zero outputs.
REQ-035 resetn pulsed on beat 2 -> all outputs 0 at once; with enable high, restart begins at ramp value 0.
